// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Edge-mode encoding plus the edge-select and saturating-increment functions.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_t;

    function automatic logic edge_select(edge_mode_t mode, logic cur, logic prev);
        logic ev;
        case (mode)
            EDGE_RISE: ev = cur & ~prev;
            EDGE_FALL: ev = ~cur & prev;
            EDGE_BOTH: ev = cur ^ prev;
            default:   ev = 1'b0;
        endcase
        return ev;
    endfunction

    // Counters wider than 32 bits are not supported by this helper.
    function automatic logic [31:0] sat_inc(logic [31:0] value, logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/edge_detector_multi_if.sv
// Channel bus of the multi-channel edge detector: raw inputs, mode, clears and results.
// master drives inputs and reads results; slave is the detector side.
interface edge_detector_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]       din;
    logic [2*NUM_CH-1:0]     mode;
    logic [NUM_CH-1:0]       status_clr;
    logic [NUM_CH-1:0]       cnt_clr;
    logic [NUM_CH-1:0]       dout;
    logic [NUM_CH-1:0]       status;
    logic [NUM_CH*CNT_W-1:0] cnt;

    modport master (
        output din, mode, status_clr, cnt_clr,
        input  dout, status, cnt
    );

    modport slave (
        input  din, mode, status_clr, cnt_clr,
        output dout, status, cnt
    );
endinterface

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, optional debounce filter, history, pulse/status/count.
// The debounce filter (and the DEB_CYCLES parameter) exists only when EDGE_DEBOUNCE_EN is defined.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
`ifdef EDGE_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES  = 4
`endif
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             din,
    input  edge_mode_t       mode,
    input  logic             status_clr,
    input  logic             cnt_clr,
    output logic             dout,
    output logic             status,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic s;
    logic f;
    logic hist;
    logic ev;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = din;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= din;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

`ifdef EDGE_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DEB_W-1:0] deb_cnt;

    // f follows s only once s has disagreed with it for DEB_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            f       <= 1'b0;
            deb_cnt <= '0;
        end else if (s == f) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            f       <= s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end
`else
    assign f = s;
`endif

    // NOTE: ev is assigned on every path of this combinational block, so no latch is inferred.
    always_comb begin
        ev = edge_select(mode, f, hist);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hist   <= 1'b0;
            dout   <= 1'b0;
            status <= 1'b0;
            cnt    <= '0;
        end else begin
            hist   <= f;
            dout   <= ev;
            status <= ev | (status & ~status_clr);
            if (cnt_clr) begin
                cnt <= ev ? CNT_W'(1) : '0;
            end else if (ev) begin
                cnt <= CNT_W'(sat_inc(32'(cnt), CNT_MAX));
            end
        end
    end

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel, mode-selectable edge detector with sticky status and saturating counts.
// Define EDGE_DEBOUNCE_EN to insert a DEB_CYCLES debounce filter in every channel.
module edge_detector_multi
    import edge_det_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
`ifdef EDGE_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES  = 4
`endif
) (
    input  logic                 clk,
    input  logic                 resetn,
    edge_detector_multi_if.slave bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_det_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef EDGE_DEBOUNCE_EN
            ,
            .DEB_CYCLES  (DEB_CYCLES)
`endif
        ) u_chan (
            .clk        (clk),
            .resetn     (resetn),
            .din        (bus.din[i]),
            .mode       (edge_mode_t'(bus.mode[2*i +: 2])),
            .status_clr (bus.status_clr[i]),
            .cnt_clr    (bus.cnt_clr[i]),
            .dout       (bus.dout[i]),
            .status     (bus.status[i]),
            .cnt        (bus.cnt[CNT_W*i +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: two instances (4ch/8-bit/2-stage sync and 2ch/2-bit/no sync)
// seen as six lanes, checked every cycle against a sample-history model plus directed literals.
module tb_edge_detector_multi;
    import edge_det_pkg::*;

    localparam int L   = 6;
    localparam int DEB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic [L-1:0] din;
    logic [L-1:0] status_clr;
    logic [L-1:0] cnt_clr;
    edge_mode_t   mode [L];

    edge_detector_multi_if #(.NUM_CH(4), .CNT_W(8)) bus0 ();
    edge_detector_multi_if #(.NUM_CH(2), .CNT_W(2)) bus1 ();

    assign bus0.din        = din[3:0];
    assign bus0.mode       = {mode[3], mode[2], mode[1], mode[0]};
    assign bus0.status_clr = status_clr[3:0];
    assign bus0.cnt_clr    = cnt_clr[3:0];
    assign bus1.din        = din[5:4];
    assign bus1.mode       = {mode[5], mode[4]};
    assign bus1.status_clr = status_clr[5:4];
    assign bus1.cnt_clr    = cnt_clr[5:4];

    edge_detector_multi #(.NUM_CH(4), .CNT_W(8), .SYNC_STAGES(2)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    edge_detector_multi #(.NUM_CH(2), .CNT_W(2), .SYNC_STAGES(0)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    // Lane view of the DUT outputs.
    logic [L-1:0] a_dout;
    logic [L-1:0] a_status;
    logic [31:0]  a_cnt [L];
    always_comb begin
        a_dout   = {bus1.dout, bus0.dout};
        a_status = {bus1.status, bus0.status};
        for (int i = 0; i < 4; i++) a_cnt[i] = 32'(bus0.cnt[8*i +: 8]);
        for (int i = 0; i < 2; i++) a_cnt[4+i] = 32'(bus1.cnt[2*i +: 2]);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane_sync(input int l);
        return (l < 4) ? 2 : 0;
    endfunction

    function automatic int lane_max(input int l);
        return (l < 4) ? 255 : 3;
    endfunction

    // Model: xh keeps the last four sampled din values per lane (index 0 = this edge).
    logic [3:0] xh [L];
    logic [1:0] fq [L];
    int         run [L];
    logic       e_dout [L];
    logic       e_status [L];
    int         e_cnt [L];
    int         cyc_n = 0;
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        cyc_n++;
        model_valid = 1'b1;
        for (int l = 0; l < L; l++) begin
            logic s, cur, prev, ev, fnew;
            if (!resetn) begin
                xh[l]       = '0;
                fq[l]       = '0;
                run[l]      = 0;
                e_dout[l]   = 1'b0;
                e_status[l] = 1'b0;
                e_cnt[l]    = 0;
            end else begin
                xh[l] = {xh[l][2:0], din[l]};
                s     = xh[l][lane_sync(l)];
`ifdef EDGE_DEBOUNCE_EN
                cur  = fq[l][0];
                prev = fq[l][1];
                fnew = fq[l][0];
                if (s != fnew) begin
                    run[l]++;
                    if (run[l] == DEB) begin
                        fnew   = s;
                        run[l] = 0;
                    end
                end else begin
                    run[l] = 0;
                end
                fq[l] = {fq[l][0], fnew};
`else
                cur  = s;
                prev = xh[l][lane_sync(l)+1];
                fnew = 1'b0;
`endif
                case (mode[l])
                    EDGE_NONE: ev = 1'b0;
                    EDGE_RISE: ev = cur && !prev;
                    EDGE_FALL: ev = !cur && prev;
                    default:   ev = (cur != prev);
                endcase
                e_dout[l] = ev;
                if (ev) e_status[l] = 1'b1;
                else if (status_clr[l]) e_status[l] = 1'b0;
                if (cnt_clr[l]) e_cnt[l] = ev ? 1 : 0;
                else if (ev && e_cnt[l] < lane_max(l)) e_cnt[l]++;
            end
        end
    end

    int pulse_cnt [L];
    int pulse_first [L];
    int pulse_last [L];
    int t0 = 0;

    always @(negedge clk) begin
        if (model_valid) begin
            for (int l = 0; l < L; l++) begin
                check($sformatf("dout_l%0d", l), 32'(a_dout[l]), 32'(e_dout[l]));
                check($sformatf("status_l%0d", l), 32'(a_status[l]), 32'(e_status[l]));
                check($sformatf("cnt_l%0d", l), a_cnt[l], e_cnt[l]);
                if (a_dout[l] === 1'b1) begin
                    if (pulse_cnt[l] == 0) pulse_first[l] = cyc_n;
                    pulse_last[l] = cyc_n;
                    pulse_cnt[l]++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        t0 = cyc_n;
        for (int l = 0; l < L; l++) begin
            pulse_cnt[l]   = 0;
            pulse_first[l] = 0;
            pulse_last[l]  = 0;
        end
    endtask

    int exp_sat [5] = '{1, 2, 3, 3, 3};

    initial begin
        resetn     = 1'b0;
        din        = '0;
        status_clr = '0;
        cnt_clr    = '0;
        for (int l = 0; l < L; l++) mode[l] = EDGE_NONE;
        clear_pulses();
        din[2]  = 1'b1;
        mode[2] = EDGE_RISE;
        repeat (3) cyc();
        settle();
        check("rst_dout", 32'(a_dout), 32'd0);
        check("rst_status", 32'(a_status), 32'd0);
        check("rst_cnt2", a_cnt[2], 32'd0);

        // din held high through reset: released high reads as a rising edge.
        cyc();
        resetn = 1'b1;
        clear_pulses();
        repeat (6) cyc();
        settle();
`ifndef EDGE_DEBOUNCE_EN
        check("t3_pulses", pulse_cnt[2], 32'd1);
        check("t3_offset", pulse_first[2] - t0, 32'd3);
        check("t3_cnt", a_cnt[2], 32'd1);
        check("t3_status", 32'(a_status[2]), 32'd1);

        // FALL on a no-sync lane: 1,1,0,0.
        cyc();
        mode[4] = EDGE_FALL;
        din[4]  = 1'b1;
        clear_pulses();
        cyc();
        din[4] = 1'b1;
        cyc();
        din[4] = 1'b0;
        repeat (4) cyc();
        settle();
        check("t1_pulses", pulse_cnt[4], 32'd1);
        check("t1_offset", pulse_first[4] - t0, 32'd3);
        check("t1_cnt", a_cnt[4], 32'd1);

        // BOTH with din toggling every cycle.
        cyc();
        mode[0] = EDGE_BOTH;
        repeat (3) cyc();
        clear_pulses();
        for (int i = 0; i < 6; i++) begin
            din[0] = ~din[0];
            cyc();
        end
        repeat (4) cyc();
        settle();
        check("t2_pulses", pulse_cnt[0], 32'd6);
        check("t2_first", pulse_first[0] - t0, 32'd3);
        check("t2_last", pulse_last[0] - t0, 32'd8);
        check("t2_cnt", a_cnt[0], 32'd6);
        check("t2_status", 32'(a_status[0]), 32'd1);

        // 2-bit counter saturation, then clear coincident with an edge, then clear alone.
        mode[5] = EDGE_RISE;
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            din[5] = 1'b1;
            cyc();
            din[5] = 1'b0;
            settle();
            check($sformatf("t4_cnt_step%0d", i), a_cnt[5], exp_sat[i]);
        end
        cyc();
        din[5]     = 1'b1;
        cnt_clr[5] = 1'b1;
        cyc();
        din[5]     = 1'b0;
        cnt_clr[5] = 1'b0;
        settle();
        check("t4_clr_with_edge", a_cnt[5], 32'd1);
        cyc();
        cnt_clr[5] = 1'b1;
        cyc();
        cnt_clr[5] = 1'b0;
        settle();
        check("t4_clr_alone", a_cnt[5], 32'd0);

        // status_clr coincident with the edge, then alone; NONE and mode change give no pulse.
        cyc();
        mode[1] = EDGE_RISE;
        din[1]  = 1'b1;
        cyc();
        cyc();
        status_clr[1] = 1'b1;
        cyc();
        status_clr[1] = 1'b0;
        settle();
        check("t5_dout_coincident", 32'(a_dout[1]), 32'd1);
        check("t5_status_set_wins", 32'(a_status[1]), 32'd1);
        cyc();
        status_clr[1] = 1'b1;
        cyc();
        status_clr[1] = 1'b0;
        settle();
        check("t5_status_cleared", 32'(a_status[1]), 32'd0);
        cyc();
        mode[1] = EDGE_NONE;
        clear_pulses();
        cyc();
        din[1] = 1'b0;
        cyc();
        cyc();
        din[1] = 1'b1;
        repeat (6) cyc();
        mode[1] = EDGE_BOTH;
        repeat (6) cyc();
        settle();
        check("t5_none_pulses", pulse_cnt[1], 32'd0);

        // Reset mid-operation drops an in-flight edge; din=1 at release is a fresh rise.
        cyc();
        din[0] = 1'b1;
        cyc();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        clear_pulses();
        settle();
        check("mid_rst_status", 32'(a_status), 32'd0);
        check("mid_rst_cnt0", a_cnt[0], 32'd0);
        check("mid_rst_cnt5", a_cnt[5], 32'd0);
        repeat (6) cyc();
        settle();
        check("mid_rst_pulses", pulse_cnt[0], 32'd1);
        check("mid_rst_offset", pulse_first[0] - t0, 32'd3);
        check("mid_rst_cnt_after", a_cnt[0], 32'd1);
`else
        check("t3_deb_pulses", pulse_cnt[2], 32'd1);
        check("t3_deb_offset", pulse_first[2] - t0, 32'(3 + DEB));

        // Debounce: a 3-cycle glitch is rejected, a 5-cycle pulse gives one rise.
        cyc();
        mode[3] = EDGE_RISE;
        repeat (4) cyc();
        clear_pulses();
        din[3] = 1'b1;
        repeat (3) cyc();
        din[3] = 1'b0;
        repeat (12) cyc();
        settle();
        check("t6_glitch_pulses", pulse_cnt[3], 32'd0);
        check("t6_glitch_status", 32'(a_status[3]), 32'd0);
        cyc();
        clear_pulses();
        din[3] = 1'b1;
        repeat (5) cyc();
        din[3] = 1'b0;
        repeat (14) cyc();
        settle();
        check("t6_pulse_count", pulse_cnt[3], 32'd1);
        check("t6_pulse_offset", pulse_first[3] - t0, 32'(3 + DEB));
        check("t6_cnt", a_cnt[3], 32'd1);
`endif

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
